raggedstone_spinn_aer_if_control: RTL and testbench

Consumes control packets produced by the SpiNNaker packet router stage (the cpkt stream) and decodes them into configuration commands for the SpiNNaker <-> AER interface.
Maintains the live configuration registers: virtual key, output mode and AER enable.
Changes to mode or enable are applied only after a quiesce handshake with the datapath, bounded by a timeout.
Illegal or malformed commands are counted in a saturating error counter.

---
 rtl/raggedstone_spinn_aer_if_control.sv | 166 ++++++++++++++++
 tb/tb_raggedstone_spinn_aer_if_control.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/raggedstone_spinn_aer_if_control.sv
`timescale 1ns/1ps
// raggedstone_spinn_aer_if_control
// Decodes SpiNNaker control packets into configuration commands for the
// SpiNNaker <-> AER interface. Holds the live vkey/mode/aer_ena registers.
// Mode/enable/restore changes go through a quiesce handshake (cfg_req/cfg_ack)
// bounded by a timeout. Bad commands and timeouts bump a saturating counter.
module raggedstone_spinn_aer_if_control #(
  parameter int          PKT_BITS = 72,
  parameter logic [31:0] VKEY_DEF = 32'h0200_0000,
  parameter logic [3:0]  MODE_DEF = 4'h0,
  parameter logic        ENA_DEF  = 1'b1,
  parameter int          ACK_TO   = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PKT_BITS-1:0] cpkt_data,
  input  logic                cpkt_vld,
  output logic                cpkt_rdy,
  output logic [31:0]         vkey,
  output logic [3:0]          mode,
  output logic                aer_ena,
  output logic                cfg_req,
  input  logic                cfg_ack,
  output logic [7:0]          err_cnt
);

  // Timeout counter only has to hold 0 .. ACK_TO-1; the abort fires on the
  // wait cycle that would bring it to ACK_TO.
  localparam int              TO_W    = (ACK_TO < 2) ? 1 : $clog2(ACK_TO + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TO - 1);

  localparam logic [3:0] CMD_SET_VKEY = 4'h0;
  localparam logic [3:0] CMD_SET_MODE = 4'h1;
  localparam logic [3:0] CMD_SET_ENA  = 4'h2;
  localparam logic [3:0] CMD_RESTORE  = 4'h3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECODE   = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  // Latched packet fields (data only, no reset needed)
  logic [3:0]      cmd_p0;
  logic            has_pl_p0;
  logic [31:0]     pl_p0;

  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_nxt;
  logic [31:0]     vkey_nxt;
  logic [3:0]      mode_nxt;
  logic            ena_nxt;
  logic            req_nxt;
  logic [7:0]      err_nxt;
  logic            xfer;
  logic            unused_pkt_bits;

  // Error counter increment that sticks at all-ones instead of wrapping
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign cpkt_rdy = (state == IDLE);
  assign xfer     = cpkt_vld && cpkt_rdy;

  // Key (router already matched it) and the rest of the header are not used
  assign unused_pkt_bits = ^{cpkt_data[39:12], cpkt_data[7:2], cpkt_data[0]};

  // Capture the command fields on transfer; cpkt_data is not looked at again
  always_ff @(posedge clk) begin
    if (xfer) begin
      cmd_p0    <= cpkt_data[11:8];
      has_pl_p0 <= cpkt_data[1];
      pl_p0     <= cpkt_data[71:40];
    end
  end

  // Next-state and next-register decode for the command FSM
  always_comb begin
    state_nxt  = state;
    vkey_nxt   = vkey;
    mode_nxt   = mode;
    ena_nxt    = aer_ena;
    req_nxt    = cfg_req;
    err_nxt    = err_cnt;
    to_cnt_nxt = to_cnt;
    case (state)
      IDLE: begin
        if (cpkt_vld) state_nxt = DECODE;
      end
      DECODE: begin
        state_nxt = IDLE;
        case (cmd_p0)
          CMD_SET_VKEY: begin
            if (has_pl_p0) vkey_nxt = pl_p0;
            else           err_nxt  = sat_inc(err_cnt);
          end
          CMD_SET_MODE, CMD_SET_ENA: begin
            if (has_pl_p0) begin
              req_nxt    = 1'b1;
              to_cnt_nxt = '0;
              state_nxt  = WAIT_ACK;
            end else begin
              err_nxt = sat_inc(err_cnt);
            end
          end
          CMD_RESTORE: begin
            req_nxt    = 1'b1;
            to_cnt_nxt = '0;
            state_nxt  = WAIT_ACK;
          end
          default: err_nxt = sat_inc(err_cnt);
        endcase
      end
      WAIT_ACK: begin
        // Ack takes priority over a timeout landing in the same cycle
        if (cfg_ack) begin
          req_nxt   = 1'b0;
          state_nxt = IDLE;
          case (cmd_p0)
            CMD_SET_MODE: mode_nxt = pl_p0[3:0];
            CMD_SET_ENA:  ena_nxt  = pl_p0[0];
            CMD_RESTORE: begin
              vkey_nxt = VKEY_DEF;
              mode_nxt = MODE_DEF;
              ena_nxt  = ENA_DEF;
            end
            default: ;
          endcase
        end else if (to_cnt == TO_LAST) begin
          req_nxt   = 1'b0;
          err_nxt   = sat_inc(err_cnt);
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and configuration registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      vkey    <= VKEY_DEF;
      mode    <= MODE_DEF;
      aer_ena <= ENA_DEF;
      cfg_req <= 1'b0;
      err_cnt <= 8'd0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      vkey    <= vkey_nxt;
      mode    <= mode_nxt;
      aer_ena <= ena_nxt;
      cfg_req <= req_nxt;
      err_cnt <= err_nxt;
      to_cnt  <= to_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_raggedstone_spinn_aer_if_control.sv
`timescale 1ns/1ps
// Bench for raggedstone_spinn_aer_if_control: directed table, hand-written
// latency/reset sequences, randomized commands against a behavioural model.
module tb_raggedstone_spinn_aer_if_control;

  localparam int          ACK_TO   = 8;
  localparam logic [31:0] VKEY_DEF = 32'h0200_0000;
  localparam logic [3:0]  MODE_DEF = 4'h0;
  localparam logic        ENA_DEF  = 1'b1;
  localparam int          NEVER    = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [71:0] cpkt_data = '0;
  logic        cpkt_vld = 1'b0;
  logic        cpkt_rdy;
  logic [31:0] vkey;
  logic [3:0]  mode;
  logic        aer_ena;
  logic        cfg_req;
  logic        cfg_ack = 1'b0;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  raggedstone_spinn_aer_if_control #(
    .PKT_BITS(72), .VKEY_DEF(VKEY_DEF), .MODE_DEF(MODE_DEF),
    .ENA_DEF(ENA_DEF), .ACK_TO(ACK_TO)
  ) dut (
    .clk(clk), .rst(rst), .cpkt_data(cpkt_data), .cpkt_vld(cpkt_vld),
    .cpkt_rdy(cpkt_rdy), .vkey(vkey), .mode(mode), .aer_ena(aer_ena),
    .cfg_req(cfg_req), .cfg_ack(cfg_ack), .err_cnt(err_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model of the configuration state
  logic [31:0] m_vkey;
  logic [3:0]  m_mode;
  logic        m_ena;
  int          m_err;

  typedef struct {
    logic [3:0]  cmd;
    logic        hp;
    logic [31:0] pl;
    int          d;
    logic [31:0] e_vkey;
    logic [3:0]  e_mode;
    logic        e_ena;
    logic [7:0]  e_err;
    int          e_wait;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_vkey = VKEY_DEF;
    m_mode = MODE_DEF;
    m_ena  = ENA_DEF;
    m_err  = 0;
  endtask

  // Expected effect of one command whose ack comes in wait cycle d+1
  task automatic model_cmd(input logic [3:0] cmd, input logic hp, input logic [31:0] pl,
                           input int d, output int exp_wait);
    exp_wait = 0;
    if (cmd == 4'h0) begin
      if (hp) m_vkey = pl;
      else    m_err  = m_err + 1;
    end else if (cmd <= 4'h3) begin
      if (cmd != 4'h3 && !hp) begin
        m_err = m_err + 1;
      end else if (d < ACK_TO) begin
        exp_wait = d + 1;
        if (cmd == 4'h1) m_mode = pl[3:0];
        else if (cmd == 4'h2) m_ena = pl[0];
        else begin
          m_vkey = VKEY_DEF;
          m_mode = MODE_DEF;
          m_ena  = ENA_DEF;
        end
      end else begin
        exp_wait = ACK_TO;
        m_err    = m_err + 1;
      end
    end else begin
      m_err = m_err + 1;
    end
    if (m_err > 255) m_err = 255;
  endtask

  // Send one packet, answer cfg_req with ack after d wait cycles, and return
  // the observed wait-cycle count, cycles until ready again, whether any
  // register moved early, and cpkt_rdy in the cycle after transfer.
  task automatic run_cmd(input logic [3:0] cmd, input logic hp, input logic [31:0] pl,
                         input int d, output int waitc, output int n,
                         output logic held_bad, output logic rdy_dec);
    logic [31:0] v0;
    logic [3:0]  md0;
    logic        e0;
    logic [7:0]  er0;
    logic [31:0] key;
    logic [7:0]  hdr;
    bit          done;
    @(negedge clk);
    v0  = vkey;
    md0 = mode;
    e0  = aer_ena;
    er0 = err_cnt;
    key = $urandom();
    key[3:0] = cmd;
    hdr = 8'($urandom());
    hdr[1] = hp;
    cpkt_data = {pl, key, hdr};
    cpkt_vld  = 1'b1;
    @(posedge clk);
    #1;
    cpkt_vld  = 1'b0;
    cpkt_data = {$urandom(), $urandom(), 8'($urandom())};
    rdy_dec   = cpkt_rdy;
    held_bad  = (vkey !== v0) || (mode !== md0) || (aer_ena !== e0) || (err_cnt !== er0);
    cfg_ack   = 1'($urandom_range(0, 1));
    waitc = 0;
    n     = 0;
    done  = 1'b0;
    while (!done && n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (cpkt_rdy) begin
        done = 1'b1;
      end else if (cfg_req) begin
        waitc++;
        cfg_ack = (waitc > d);
        if ((vkey !== v0) || (mode !== md0) || (aer_ena !== e0) || (err_cnt !== er0))
          held_bad = 1'b1;
      end
    end
    cfg_ack = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [31:0] ev, input logic [3:0] em,
                           input logic ee, input logic [7:0] er, input int ew,
                           input int wc, input int n, input logic hb, input logic rd);
    check({tag, "_vkey"},    vkey,            ev);
    check({tag, "_mode"},    32'(mode),       32'(em));
    check({tag, "_ena"},     32'(aer_ena),    32'(ee));
    check({tag, "_err"},     32'(err_cnt),    32'(er));
    check({tag, "_wait"},    32'(wc),         32'(ew));
    check({tag, "_lat"},     32'(n),          32'(ew + 1));
    check({tag, "_held"},    32'(hb),         32'd0);
    check({tag, "_rdy_dec"}, 32'(rd),         32'd0);
    check({tag, "_req_end"}, 32'(cfg_req),    32'd0);
  endtask

  task automatic do_and_check(input string tag, input logic [3:0] cmd, input logic hp,
                              input logic [31:0] pl, input int d);
    int   ew;
    int   wc;
    int   n;
    logic hb;
    logic rd;
    model_cmd(cmd, hp, pl, d, ew);
    run_cmd(cmd, hp, pl, d, wc, n, hb, rd);
    check_all(tag, m_vkey, m_mode, m_ena, 8'(m_err), ew, wc, n, hb, rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   wc;
    int   n;
    logic hb;
    logic rd;

    //                cmd   hp    pl            d      vkey          mode  ena   err  wait
    tbl[0]  = '{4'h0, 1'b1, 32'hDEAD_BEEF, 0,     32'hDEAD_BEEF, 4'h0, 1'b1, 8'd0, 0};
    tbl[1]  = '{4'h1, 1'b1, 32'd5,         5,     32'hDEAD_BEEF, 4'h5, 1'b1, 8'd0, 6};
    tbl[2]  = '{4'h2, 1'b1, 32'd0,         NEVER, 32'hDEAD_BEEF, 4'h5, 1'b1, 8'd1, 8};
    tbl[3]  = '{4'h2, 1'b1, 32'd0,         7,     32'hDEAD_BEEF, 4'h5, 1'b0, 8'd1, 8};
    tbl[4]  = '{4'h7, 1'b1, 32'd0,         0,     32'hDEAD_BEEF, 4'h5, 1'b0, 8'd2, 0};
    tbl[5]  = '{4'h0, 1'b0, 32'h1234,      0,     32'hDEAD_BEEF, 4'h5, 1'b0, 8'd3, 0};
    tbl[6]  = '{4'h0, 1'b1, 32'd1,         0,     32'd1,         4'h5, 1'b0, 8'd3, 0};
    tbl[7]  = '{4'h1, 1'b1, 32'hFFFF_FFF3, 0,     32'd1,         4'h3, 1'b0, 8'd3, 1};
    tbl[8]  = '{4'h2, 1'b1, 32'hFFFF_FFFE, 2,     32'd1,         4'h3, 1'b0, 8'd3, 3};
    tbl[9]  = '{4'h3, 1'b0, 32'h0000_ABCD, 1,     32'h0200_0000, 4'h0, 1'b1, 8'd3, 2};
    tbl[10] = '{4'h1, 1'b0, 32'd7,         0,     32'h0200_0000, 4'h0, 1'b1, 8'd4, 0};
    tbl[11] = '{4'hF, 1'b1, 32'd0,         0,     32'h0200_0000, 4'h0, 1'b1, 8'd5, 0};

    // Reset release, idle for 5 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_vkey",    vkey,          32'h0200_0000);
    check("rst_mode",    32'(mode),     32'd0);
    check("rst_ena",     32'(aer_ena),  32'd1);
    check("rst_req",     32'(cfg_req),  32'd0);
    check("rst_err",     32'(err_cnt),  32'd0);
    check("rst_rdy",     32'(cpkt_rdy), 32'd1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_cmd(tbl[i].cmd, tbl[i].hp, tbl[i].pl, tbl[i].d, wc, n, hb, rd);
      check_all($sformatf("tbl%0d", i), tbl[i].e_vkey, tbl[i].e_mode, tbl[i].e_ena,
                tbl[i].e_err, tbl[i].e_wait, wc, n, hb, rd);
    end
    m_vkey = tbl[11].e_vkey;
    m_mode = tbl[11].e_mode;
    m_ena  = tbl[11].e_ena;
    m_err  = int'(tbl[11].e_err);

    // Randomized commands against the model
    for (int i = 0; i < 150; i++) begin
      logic [3:0] c;
      logic       h;
      int         dl;
      c  = ($urandom_range(0, 4) == 4) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      h  = ($urandom_range(0, 3) != 0);
      dl = int'($urandom_range(0, 10));
      do_and_check($sformatf("rnd%0d", i), c, h, $urandom(), dl);
    end

    // Reset while waiting for ack: pending SET_MODE must be lost
    @(negedge clk);
    cpkt_data = {32'd9, 32'h0000_0001, 8'h02};
    cpkt_vld  = 1'b1;
    @(posedge clk);
    #1;
    cpkt_vld = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_req_before", 32'(cfg_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_req",  32'(cfg_req),  32'd0);
    check("midrst_vkey", vkey,          VKEY_DEF);
    check("midrst_mode", 32'(mode),     32'(MODE_DEF));
    check("midrst_ena",  32'(aer_ena),  32'(ENA_DEF));
    check("midrst_err",  32'(err_cnt),  32'd0);
    check("midrst_rdy",  32'(cpkt_rdy), 32'd1);
    @(negedge clk);
    rst     = 1'b1;
    cfg_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cfg_ack = 1'b0;
    check("postrst_mode", 32'(mode),    32'(MODE_DEF));
    check("postrst_req",  32'(cfg_req), 32'd0);
    model_reset();

    // 300 bad commands saturate the error counter
    for (int i = 0; i < 300; i++)
      do_and_check($sformatf("sat%0d", i), 4'h7, 1'b1, 32'd0, 0);
    check("sat_final", 32'(err_cnt), 32'h0000_00FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
